// File: rtl/bus_pkg.sv
// Shared constants for the 6-to-4 bus unpacker and its bit buffer.
package bus_pkg;

  localparam int unsigned BUS_IN_W  = 6;
  localparam int unsigned BUS_OUT_W = 4;
  localparam int unsigned BUS_BUF_W = 12;

  // Width needed to hold a bit count in the range 0..buf_w inclusive.
  function automatic int unsigned cnt_width(input int unsigned buf_w);
    return $clog2(buf_w + 1);
  endfunction

endpackage

// File: rtl/bus_unpack_6to4_if.sv
// Valid/ready word input, nibble output, flush request and busy status of the unpacker.
interface bus_unpack_6to4_if
  import bus_pkg::*;
#(
  parameter int unsigned IN_W  = BUS_IN_W,
  parameter int unsigned OUT_W = BUS_OUT_W
);

  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             flush;
  logic             busy;

  modport master (
    output in_data, in_valid, out_ready, flush,
    input  in_ready, out_data, out_valid, busy
  );

  modport slave (
    input  in_data, in_valid, out_ready, flush,
    output in_ready, out_data, out_valid, busy
  );

endinterface

// File: rtl/bus_bitbuf.sv
// LSB-first bit buffer: pops OUT_W bits off the bottom, then appends IN_W bits above the count.
module bus_bitbuf
  import bus_pkg::*;
#(
  parameter int unsigned IN_W  = BUS_IN_W,
  parameter int unsigned OUT_W = BUS_OUT_W,
  parameter int unsigned BUF_W = BUS_BUF_W,
  parameter int unsigned CNT_W = cnt_width(BUF_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic             pop,
  input  logic             flush_pop,
  input  logic [IN_W-1:0]  in_data,
  output logic [OUT_W-1:0] head,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_next
);

  logic [BUF_W-1:0] bits_q, bits_d, bits_pop;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_pop;

  always_comb begin
    bits_pop = bits_q;
    cnt_pop  = cnt_q;
    if (pop) begin
      bits_pop = bits_q >> OUT_W;
      // A flush pop carries fewer than OUT_W real bits, so the count empties outright.
      cnt_pop  = flush_pop ? '0 : cnt_q - CNT_W'(OUT_W);
    end
    bits_d = bits_pop;
    cnt_d  = cnt_pop;
    if (accept) begin
      bits_d = bits_pop | ({{(BUF_W-IN_W){1'b0}}, in_data} << cnt_pop);
      cnt_d  = cnt_pop + CNT_W'(IN_W);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits_q <= '0;
      cnt_q  <= '0;
    end else begin
      bits_q <= bits_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head     = bits_q[OUT_W-1:0];
  assign cnt      = cnt_q;
  assign cnt_next = cnt_d;

endmodule

// File: rtl/bus_unpack_6to4.sv
// 6-bit word to 4-bit nibble gearbox with valid/ready on both sides and a residue flush.
module bus_unpack_6to4
  import bus_pkg::*;
#(
  parameter int unsigned IN_W  = BUS_IN_W,
  parameter int unsigned OUT_W = BUS_OUT_W,
  parameter int unsigned BUF_W = BUS_BUF_W
) (
  input  logic             clk,
  input  logic             rst,
  bus_unpack_6to4_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(BUF_W);

  if (BUF_W < IN_W + OUT_W) begin : gen_bad_buf_w
    $error("BUF_W must be at least IN_W + OUT_W");
  end

  logic [CNT_W-1:0] cnt, cnt_next;
  logic [OUT_W-1:0] head;
  logic             flush_pend_q, flush_pend_d;
  logic             accept, pop, flush_pop;
  logic             has_nibble;

  assign has_nibble    = cnt >= CNT_W'(OUT_W);
  assign bus.in_ready  = (cnt <= CNT_W'(BUF_W - IN_W)) && !flush_pend_q;
  assign bus.out_valid = has_nibble || (flush_pend_q && cnt != '0);
  assign bus.out_data  = head;
  assign bus.busy      = (cnt != '0) || flush_pend_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign pop       = bus.out_valid && bus.out_ready;
  assign flush_pop = pop && !has_nibble;

  // Judged on the post-update count so a same-cycle accept joins the flush and
  // an empty buffer ignores the request.
  assign flush_pend_d = (flush_pend_q || bus.flush) && (cnt_next != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_pend_q <= 1'b0;
    end else begin
      flush_pend_q <= flush_pend_d;
    end
  end

  bus_bitbuf #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .BUF_W (BUF_W),
    .CNT_W (CNT_W)
  ) u_bitbuf (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .pop       (pop),
    .flush_pop (flush_pop),
    .in_data   (bus.in_data),
    .head      (head),
    .cnt       (cnt),
    .cnt_next  (cnt_next)
  );

endmodule

// File: tb/tb_bus_unpack_6to4.sv
// Directed bench for bus_unpack_6to4: hand-computed nibble sequences per scenario.
module tb_bus_unpack_6to4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bus_unpack_6to4_if bus_if ();

  bus_unpack_6to4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b0;
    bus_if.flush     = 1'b0;
    #3;
    checks += 4;
    if (bus_if.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus_if.out_valid); end
    if (bus_if.out_data !== 4'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", bus_if.out_data); end
    if (bus_if.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus_if.in_ready); end
    if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus_if.busy); end
    @(negedge clk);
    rst = 1'b0;
    cyc();
  endtask

  // 6'h2D, 6'h13 -> D, E, 4 with out_ready held high.
  task automatic test_basic();
    bus_if.out_ready = 1'b1;
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = 6'h2D;
    checks += 2;
    if (bus_if.in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready0 got=%b exp=1", bus_if.in_ready); end
    if (bus_if.out_valid !== 1'b0) begin failures++; $display("FAIL basic_ov_before got=%b exp=0", bus_if.out_valid); end
    cyc();
    bus_if.in_data = 6'h13;
    checks += 2;
    if (bus_if.out_valid !== 1'b1) begin failures++; $display("FAIL basic_latency got=%b exp=1", bus_if.out_valid); end
    if (bus_if.out_data !== 4'hD) begin failures++; $display("FAIL basic_nib0 got=%h exp=d", bus_if.out_data); end
    cyc();
    bus_if.in_valid = 1'b0;
    checks += 2;
    if (bus_if.out_data !== 4'hE) begin failures++; $display("FAIL basic_nib1 got=%h exp=e", bus_if.out_data); end
    if (bus_if.in_ready !== 1'b0) begin failures++; $display("FAIL basic_in_ready_cnt8 got=%b exp=0", bus_if.in_ready); end
    cyc();
    checks += 2;
    if (bus_if.out_valid !== 1'b1) begin failures++; $display("FAIL basic_ov2 got=%b exp=1", bus_if.out_valid); end
    if (bus_if.out_data !== 4'h4) begin failures++; $display("FAIL basic_nib2 got=%h exp=4", bus_if.out_data); end
    cyc();
    checks += 2;
    if (bus_if.out_valid !== 1'b0) begin failures++; $display("FAIL basic_ov_end got=%b exp=0", bus_if.out_valid); end
    if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end got=%b exp=0", bus_if.busy); end
  endtask

  task automatic test_backpressure();
    bus_if.out_ready = 1'b0;
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = 6'h2D;
    cyc();
    bus_if.in_data = 6'h13;
    checks += 2;
    if (bus_if.in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_cnt6 got=%b exp=1", bus_if.in_ready); end
    if (bus_if.out_data !== 4'hD) begin failures++; $display("FAIL bp_nib0 got=%h exp=d", bus_if.out_data); end
    cyc();
    bus_if.in_valid = 1'b0;
    checks += 2;
    if (bus_if.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_cnt12 got=%b exp=0", bus_if.in_ready); end
    if (bus_if.out_data !== 4'hD) begin failures++; $display("FAIL bp_hold0 got=%h exp=d", bus_if.out_data); end
    cyc();
    cyc();
    checks += 2;
    if (bus_if.out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid got=%b exp=1", bus_if.out_valid); end
    if (bus_if.out_data !== 4'hD) begin failures++; $display("FAIL bp_hold1 got=%h exp=d", bus_if.out_data); end
    bus_if.out_ready = 1'b1;
    cyc();
    checks += 2;
    if (bus_if.out_data !== 4'hE) begin failures++; $display("FAIL bp_nib1 got=%h exp=e", bus_if.out_data); end
    if (bus_if.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_cnt8 got=%b exp=0", bus_if.in_ready); end
    cyc();
    checks += 2;
    if (bus_if.out_data !== 4'h4) begin failures++; $display("FAIL bp_nib2 got=%h exp=4", bus_if.out_data); end
    if (bus_if.in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_cnt4 got=%b exp=1", bus_if.in_ready); end
    cyc();
    checks += 1;
    if (bus_if.out_valid !== 1'b0) begin failures++; $display("FAIL bp_ov_end got=%b exp=0", bus_if.out_valid); end
  endtask

  task automatic test_flush_residue();
    bus_if.out_ready = 1'b1;
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = 6'h3F;
    cyc();
    bus_if.in_valid = 1'b0;
    checks += 1;
    if (bus_if.out_data !== 4'hF) begin failures++; $display("FAIL fr_nib0 got=%h exp=f", bus_if.out_data); end
    cyc();
    checks += 3;
    if (bus_if.out_valid !== 1'b0) begin failures++; $display("FAIL fr_residue_ov got=%b exp=0", bus_if.out_valid); end
    if (bus_if.busy !== 1'b1) begin failures++; $display("FAIL fr_residue_busy got=%b exp=1", bus_if.busy); end
    if (bus_if.in_ready !== 1'b1) begin failures++; $display("FAIL fr_residue_in_ready got=%b exp=1", bus_if.in_ready); end
    bus_if.flush = 1'b1;
    cyc();
    bus_if.flush = 1'b0;
    checks += 3;
    if (bus_if.out_valid !== 1'b1) begin failures++; $display("FAIL fr_pad_ov got=%b exp=1", bus_if.out_valid); end
    if (bus_if.out_data !== 4'h3) begin failures++; $display("FAIL fr_pad_nib got=%h exp=3", bus_if.out_data); end
    if (bus_if.in_ready !== 1'b0) begin failures++; $display("FAIL fr_pend_in_ready got=%b exp=0", bus_if.in_ready); end
    cyc();
    checks += 3;
    if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL fr_end_busy got=%b exp=0", bus_if.busy); end
    if (bus_if.in_ready !== 1'b1) begin failures++; $display("FAIL fr_end_in_ready got=%b exp=1", bus_if.in_ready); end
    if (bus_if.out_valid !== 1'b0) begin failures++; $display("FAIL fr_end_ov got=%b exp=0", bus_if.out_valid); end
  endtask

  task automatic test_flush_empty();
    bus_if.flush = 1'b1;
    cyc();
    bus_if.flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks += 3;
      if (bus_if.out_valid !== 1'b0) begin failures++; $display("FAIL fe_ov c=%0d got=%b exp=0", c, bus_if.out_valid); end
      if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL fe_busy c=%0d got=%b exp=0", c, bus_if.busy); end
      if (bus_if.in_ready !== 1'b1) begin failures++; $display("FAIL fe_in_ready c=%0d got=%b exp=1", c, bus_if.in_ready); end
      cyc();
    end
  endtask

  // Flush arriving with the accepting word: the word is drained, residue padded.
  task automatic test_flush_with_accept();
    bus_if.out_ready = 1'b0;
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = 6'h2D;
    bus_if.flush     = 1'b1;
    cyc();
    bus_if.in_valid = 1'b0;
    bus_if.flush    = 1'b0;
    checks += 3;
    if (bus_if.in_ready !== 1'b0) begin failures++; $display("FAIL fa_in_ready got=%b exp=0", bus_if.in_ready); end
    if (bus_if.busy !== 1'b1) begin failures++; $display("FAIL fa_busy got=%b exp=1", bus_if.busy); end
    if (bus_if.out_data !== 4'hD) begin failures++; $display("FAIL fa_nib0 got=%h exp=d", bus_if.out_data); end
    bus_if.out_ready = 1'b1;
    cyc();
    checks += 2;
    if (bus_if.out_valid !== 1'b1) begin failures++; $display("FAIL fa_pad_ov got=%b exp=1", bus_if.out_valid); end
    if (bus_if.out_data !== 4'h2) begin failures++; $display("FAIL fa_pad_nib got=%h exp=2", bus_if.out_data); end
    cyc();
    checks += 2;
    if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL fa_end_busy got=%b exp=0", bus_if.busy); end
    if (bus_if.out_valid !== 1'b0) begin failures++; $display("FAIL fa_end_ov got=%b exp=0", bus_if.out_valid); end
  endtask

  // 00,3F,15,2A -> 24 bits -> nibbles 0,C,F,5,9,A; exactly one stall cycle.
  task automatic test_stream();
    logic [5:0] words [4];
    logic [3:0] exp_nib [6];
    int  wi, ni, stalls;
    bit  acc, pop;
    words   = '{6'h00, 6'h3F, 6'h15, 6'h2A};
    exp_nib = '{4'h0, 4'hC, 4'hF, 4'h5, 4'h9, 4'hA};
    wi = 0; ni = 0; stalls = 0;
    bus_if.out_ready = 1'b1;
    for (int c = 0; c < 40 && (wi < 4 || ni < 6); c++) begin
      if (wi < 4) begin
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = words[wi];
      end else begin
        bus_if.in_valid = 1'b0;
      end
      acc = bus_if.in_valid && bus_if.in_ready;
      pop = bus_if.out_valid && bus_if.out_ready;
      if (bus_if.in_valid && !bus_if.in_ready) stalls++;
      if (pop) begin
        checks++;
        if (ni >= 6) begin
          failures++; $display("FAIL stream_extra got=%h exp=none", bus_if.out_data);
        end else if (bus_if.out_data !== exp_nib[ni]) begin
          failures++; $display("FAIL stream_nib%0d got=%h exp=%h", ni, bus_if.out_data, exp_nib[ni]);
        end
        ni++;
      end
      cyc();
      if (acc) wi++;
    end
    bus_if.in_valid = 1'b0;
    checks += 4;
    if (ni != 6) begin failures++; $display("FAIL stream_nibble_count got=%0d exp=6", ni); end
    if (wi != 4) begin failures++; $display("FAIL stream_word_count got=%0d exp=4", wi); end
    if (stalls != 1) begin failures++; $display("FAIL stream_stalls got=%0d exp=1", stalls); end
    if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL stream_busy_end got=%b exp=0", bus_if.busy); end
  endtask

  task automatic test_async_reset();
    bus_if.out_ready = 1'b0;
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = 6'h2D;
    cyc();
    bus_if.in_valid = 1'b0;
    checks += 1;
    if (bus_if.out_data !== 4'hD) begin failures++; $display("FAIL ar_pre_nib got=%h exp=d", bus_if.out_data); end
    #2 rst = 1'b1;
    #1;
    checks += 4;
    if (bus_if.out_valid !== 1'b0) begin failures++; $display("FAIL ar_out_valid got=%b exp=0", bus_if.out_valid); end
    if (bus_if.out_data !== 4'h0) begin failures++; $display("FAIL ar_out_data got=%h exp=0", bus_if.out_data); end
    if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL ar_busy got=%b exp=0", bus_if.busy); end
    if (bus_if.in_ready !== 1'b1) begin failures++; $display("FAIL ar_in_ready got=%b exp=1", bus_if.in_ready); end
    #2 rst = 1'b0;
    bus_if.out_ready = 1'b1;
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = 6'h13;
    cyc();
    bus_if.in_valid = 1'b0;
    bus_if.flush    = 1'b1;
    checks += 1;
    if (bus_if.out_data !== 4'h3) begin failures++; $display("FAIL ar_nib0 got=%h exp=3", bus_if.out_data); end
    cyc();
    bus_if.flush = 1'b0;
    checks += 3;
    if (bus_if.out_valid !== 1'b1) begin failures++; $display("FAIL ar_pad_ov got=%b exp=1", bus_if.out_valid); end
    if (bus_if.out_data !== 4'h1) begin failures++; $display("FAIL ar_pad_nib got=%h exp=1", bus_if.out_data); end
    if (bus_if.in_ready !== 1'b0) begin failures++; $display("FAIL ar_pend_in_ready got=%b exp=0", bus_if.in_ready); end
    cyc();
    checks += 2;
    if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL ar_end_busy got=%b exp=0", bus_if.busy); end
    if (bus_if.out_valid !== 1'b0) begin failures++; $display("FAIL ar_end_ov got=%b exp=0", bus_if.out_valid); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_flush_residue();
    test_flush_empty();
    test_flush_with_accept();
    test_stream();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
